sound_arbiter: RTL and testbench
================================

SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of sound requesters; index 0 has highest priority.
REQ-002 Parameter TONE_W, default 17: width of each half-period field, in clk cycles.
REQ-003 Parameter DUR_W, default 24: width of each duration field, in clk cycles.
REQ-004 Parameter GAP_CYCLES, default 1000: silent cycles inserted after every completed tone.
REQ-005 clk  input  1: single system clock (25.1 MHz pixel clock); all state SHALL be on its rising edge.
REQ-006 reset  input  1: asynchronous, active-high reset.
REQ-007 req  input  NUM_REQ: level request per sound source (jump, death, score, level); a 0->1 edge triggers the sound.
REQ-008 half_period  input  NUM_REQ*TONE_W: per-requester half period; field i = bits [i*TONE_W +: TONE_W].
REQ-009 duration  input  NUM_REQ*DUR_W: per-requester tone length; field i = bits [i*DUR_W +: DUR_W].
REQ-010 sound_out  output  1: square-wave drive to the speaker pin.
REQ-011 busy  output  1: high while in PLAY or GAP.
REQ-012 active_id  output  $clog2(NUM_REQ): index of the requester most recently granted.
REQ-013 grant  output  NUM_REQ: one-hot, one-cycle pulse marking the requester whose tone starts.

Function
REQ-014 Each req bit SHALL be registered each cycle, and a rising edge SHALL be detected against that registered copy.
REQ-015 A detected edge SHALL set pending[i] on the same clk edge; pending[i] SHALL stay set until requester i is granted.
REQ-016 The state machine SHALL have three states: IDLE, PLAY and GAP.
REQ-017 IDLE with pending != 0: the block SHALL pick the lowest set index i, clear pending[i], pulse grant[i], set active_id=i, latch half_period[i] and duration[i], and go to PLAY with sound_out=1, all on one edge.
REQ-018 IDLE with pending == 0: the block SHALL hold sound_out=0 and busy=0.
REQ-019 PLAY, tone counter: the counter SHALL run 0..hp-1, where hp is the latched half period; at hp-1 it SHALL wrap to 0 and sound_out SHALL toggle; a latched half period of 0 SHALL be treated as 1.
REQ-020 PLAY, duration: the duration counter SHALL decrement once per cycle, so sound_out is driven by the tone for exactly the latched duration in cycles; at 1 the block SHALL go to GAP with sound_out=0.
REQ-021 A latched duration of 0 SHALL go directly from IDLE to GAP; grant SHALL still pulse and sound_out SHALL stay 0.
REQ-022 GAP: sound_out SHALL be 0 for exactly GAP_CYCLES cycles, then the block SHALL go to IDLE.
REQ-023 Preemption, PLAY or GAP: if any pending[j] is set with j < active_id, the block SHALL abort the current tone and perform the REQ-017 load for j on the next edge (state PLAY).
REQ-024 Pending entries with j >= active_id SHALL queue and SHALL NOT preempt.
REQ-025 A re-edge on the active requester SHALL set its pending bit, so the tone replays after GAP.
REQ-026 A new edge on a requester whose pending bit is already set SHALL be absorbed; there SHALL be no counting.
REQ-027 When pending[i] is set and cleared by a grant on the same edge, the set SHALL win.
REQ-028 half_period and duration SHALL be sampled only at grant; later changes SHALL NOT affect a tone in progress.
REQ-029 All counters SHALL be unsigned and sized to their field widths, with no overflow beyond those widths.

Reset
REQ-030 Reset SHALL immediately set: state=IDLE, pending=0, registered req=0, counters=0, sound_out=0, busy=0, grant=0, active_id=0.
REQ-031 A reset asserted during PLAY SHALL silence the output at once, and the aborted tone SHALL NOT resume.
REQ-032 A req held high through reset deassertion SHALL produce an edge on the first cycle after release, because the registered copy resets to 0.

Verification
REQ-033 Basic tone: req[1] pulse with hp1=3, dur1=20, GAP_CYCLES=4 -> grant[1] is one cycle; sound_out reads 111000111000111000 11 (20 cycles); 4 zero cycles follow; then busy=0.
REQ-034 Simultaneous edges: edges on req[0] and req[2] together -> grant[0] first; grant[2] comes after tone 0 plus its gap; active_id goes 0 then 2.
REQ-035 Preemption: req[3] plays (dur=100), and req[0] rises at cycle 10 of the tone -> grant[0] arrives 2 cycles later, tone 3 is dropped, and req[2] rising during tone 0 waits for it.
REQ-036 Zero fields: hp=0, dur=6 gives sound_out toggling every cycle for 6 cycles; dur=0 gives a grant pulse, sound_out=0 and GAP only.
REQ-037 Reset mid-PLAY: assert reset mid-tone -> sound_out, busy and pending all read 0 before the next clk edge; with req held high, a grant comes 2 cycles after release.

Source files
------------

// File: rtl/sound_arbiter_if.sv
// Request/tone bus between the sound sources and the sound arbiter.
// The arbiter takes the slave side; the requester/speaker side takes the master side.
interface sound_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TONE_W  = 17,
  parameter int DUR_W   = 24,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*TONE_W-1:0] half_period;
  logic [NUM_REQ*DUR_W-1:0]  duration;
  logic                      sound_out;
  logic                      busy;
  logic [ID_W-1:0]           active_id;
  logic [NUM_REQ-1:0]        grant;

  modport master (
    output req, half_period, duration,
    input  sound_out, busy, active_id, grant
  );

  modport slave (
    input  req, half_period, duration,
    output sound_out, busy, active_id, grant
  );

endinterface

// File: rtl/sound_arbiter.sv
// Fixed-priority square-wave tone arbiter: edge-triggered requests queue as pending
// bits, the lowest index plays (preempting higher indices), and each tone ends in a silent gap.
module sound_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TONE_W     = 17,
  parameter int DUR_W      = 24,
  parameter int GAP_CYCLES = 1000   // expected to be at least 1
) (
  input  logic           clk,
  input  logic           reset,
  sound_arbiter_if.slave bus
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_req;
  logic [NUM_REQ-1:0]  r_pending;
  logic [NUM_REQ-1:0]  r_grant;
  logic [ID_W-1:0]     r_active_id;
  logic                r_sound_out;
  logic                r_busy;
  logic [TONE_W-1:0]   r_hp;
  logic [TONE_W-1:0]   r_tone_cnt;
  logic [DUR_W-1:0]    r_dur;
  logic [GAP_W-1:0]    r_gap_cnt;

  logic [NUM_REQ-1:0]  w_edge;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic [NUM_REQ-1:0]  w_pending_nxt;
  logic [ID_W-1:0]     w_pick_id;
  logic [TONE_W-1:0]   w_sel_hp;
  logic [DUR_W-1:0]    w_sel_dur;
  logic [TONE_W-1:0]   w_hp_last;
  logic                w_preempt;
  logic                w_load;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_edge    = bus.req & ~r_req;
    w_pick_id = '0;
    w_sel_hp  = '0;
    w_sel_dur = '0;
    // Walking down from the top leaves the lowest pending index selected.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_pick_id = ID_W'(i);
        w_sel_hp  = bus.half_period[i*TONE_W +: TONE_W];
        w_sel_dur = bus.duration[i*DUR_W +: DUR_W];
      end
    end

    w_preempt = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_pending[i] && (i < int'(r_active_id))) w_preempt = 1'b1;
    end

    w_load     = (r_state == S_IDLE) ? (|r_pending) : w_preempt;
    w_grant_oh = '0;
    if (w_load) w_grant_oh[w_pick_id] = 1'b1;

    // A fresh edge outranks the grant clear, so a same-cycle re-trigger is kept.
    w_pending_nxt = (r_pending & ~w_grant_oh) | w_edge;

    w_hp_last = (r_hp == '0) ? '0 : (r_hp - TONE_W'(1));
  end

  // NOTE: state registers use non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_req       <= '0;
      r_pending   <= '0;
      r_grant     <= '0;
      r_active_id <= '0;
      r_sound_out <= 1'b0;
      r_busy      <= 1'b0;
      r_hp        <= '0;
      r_tone_cnt  <= '0;
      r_dur       <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_req     <= bus.req;
      r_pending <= w_pending_nxt;
      r_grant   <= w_grant_oh;

      if (w_load) begin
        r_active_id <= w_pick_id;
        r_hp        <= w_sel_hp;
        r_dur       <= w_sel_dur;
        r_tone_cnt  <= '0;
        r_busy      <= 1'b1;
        if (w_sel_dur == '0) begin
          r_state     <= S_GAP;
          r_sound_out <= 1'b0;
          r_gap_cnt   <= GAP_LOAD;
        end else begin
          r_state     <= S_PLAY;
          r_sound_out <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sound_out <= 1'b0;
            r_busy      <= 1'b0;
          end

          S_PLAY: begin
            if (r_dur == DUR_W'(1)) begin
              r_state     <= S_GAP;
              r_sound_out <= 1'b0;
              r_gap_cnt   <= GAP_LOAD;
            end else begin
              r_dur <= r_dur - DUR_W'(1);
              if (r_tone_cnt == w_hp_last) begin
                r_tone_cnt  <= '0;
                r_sound_out <= ~r_sound_out;
              end else begin
                r_tone_cnt <= r_tone_cnt + TONE_W'(1);
              end
            end
          end

          S_GAP: begin
            if (r_gap_cnt == '0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.sound_out = r_sound_out;
  assign bus.busy      = r_busy;
  assign bus.active_id = r_active_id;
  assign bus.grant     = r_grant;

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter: tone shape, priority, preemption, zero fields,
// re-trigger handling and reset behaviour, with hand-derived expectations.
module tb_sound_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TONE_W  = 17;
  localparam int DUR_W   = 24;
  localparam int GAP     = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   waited;

  sound_arbiter_if #(.NUM_REQ(NUM_REQ), .TONE_W(TONE_W), .DUR_W(DUR_W)) bus ();

  sound_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .TONE_W    (TONE_W),
    .DUR_W     (DUR_W),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_fields(input int id, input int hp, input int dur);
    bus.half_period[id*TONE_W +: TONE_W] = TONE_W'(hp);
    bus.duration[id*DUR_W +: DUR_W]      = DUR_W'(dur);
  endtask

  // Called on a negedge; waits (bounded) for a grant, then checks grant, id and latency.
  task automatic wait_grant(input string tag, input logic [3:0] exp_grant,
                            input int exp_id, input int exp_wait);
    int w;
    w = 0;
    while (bus.grant == '0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_grant"}, bus.grant, exp_grant);
    check({tag, "_id"}, bus.active_id, exp_id);
    check({tag, "_lat"}, w, exp_wait);
    waited = w;
  endtask

  // Checks tone cycles t0..dur-1, the gap, and the return to idle.
  task automatic check_tone(input string tag, input int hp_eff, input int dur, input int t0);
    for (int t = t0; t < dur; t++) begin
      check({tag, "_so"}, bus.sound_out, ((t / hp_eff) % 2) == 0);
      check({tag, "_busy"}, bus.busy, 1'b1);
      if (t > 0) check({tag, "_gr0"}, bus.grant, 4'b0000);
      @(negedge clk);
    end
    for (int g = 0; g < GAP; g++) begin
      check({tag, "_gap_so"}, bus.sound_out, 1'b0);
      check({tag, "_gap_busy"}, bus.busy, 1'b1);
      @(negedge clk);
    end
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
    check({tag, "_idle_so"}, bus.sound_out, 1'b0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.grant != '0 || bus.busy) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.req  = '0;
    bus.half_period = '0;
    bus.duration    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_so", bus.sound_out, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_grant", bus.grant, 4'b0000);
    check("rst_id", bus.active_id, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);

    // Basic tone on req[1]; fields change mid-tone must not matter
    set_fields(1, 3, 20);
    bus.req[1] = 1'b1;
    wait_grant("t1", 4'b0010, 1, 2);
    bus.req[1] = 1'b0;
    set_fields(1, 7, 50);
    check_tone("t1", 3, 20, 0);

    // Simultaneous edges on 0 and 2; a re-edge on 2 as it is granted must be kept
    set_fields(0, 2, 5);
    set_fields(2, 1, 3);
    bus.req[0] = 1'b1;
    bus.req[2] = 1'b1;
    @(negedge clk);
    check("t2_early", bus.grant, 4'b0000);
    bus.req[0] = 1'b0;
    bus.req[2] = 1'b0;
    wait_grant("t2a", 4'b0001, 0, 1);
    check_tone("t2a", 2, 5, 0);
    bus.req[2] = 1'b1;
    wait_grant("t2b", 4'b0100, 2, 1);
    bus.req[2] = 1'b0;
    check_tone("t2b", 1, 3, 0);
    wait_grant("t2c", 4'b0100, 2, 1);
    check_tone("t2c", 1, 3, 0);
    expect_quiet("t2_quiet", 10);

    // Preemption of req[3] by req[0]; req[2] queues behind tone 0
    set_fields(3, 5, 100);
    set_fields(0, 4, 8);
    set_fields(2, 3, 6);
    bus.req[3] = 1'b1;
    wait_grant("t3a", 4'b1000, 3, 2);
    bus.req[3] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      check("t3a_so", bus.sound_out, ((t / 5) % 2) == 0);
      @(negedge clk);
    end
    bus.req[0] = 1'b1;
    wait_grant("t3b", 4'b0001, 0, 2);
    bus.req[0] = 1'b0;
    bus.req[2] = 1'b1;
    check_tone("t3b", 4, 8, 0);
    bus.req[2] = 1'b0;
    wait_grant("t3c", 4'b0100, 2, 1);
    check_tone("t3c", 3, 6, 0);
    expect_quiet("t3_dropped", 20);

    // Zero half period and zero duration
    set_fields(1, 0, 6);
    bus.req[1] = 1'b1;
    wait_grant("t4a", 4'b0010, 1, 2);
    bus.req[1] = 1'b0;
    check_tone("t4a", 1, 6, 0);
    set_fields(2, 5, 0);
    bus.req[2] = 1'b1;
    wait_grant("t4b", 4'b0100, 2, 2);
    bus.req[2] = 1'b0;
    check_tone("t4b", 1, 0, 0);

    // Re-edges on the active requester: one replay, extra edge absorbed
    set_fields(1, 2, 6);
    bus.req[1] = 1'b1;
    wait_grant("t5a", 4'b0010, 1, 2);
    for (int t = 0; t < 4; t++) begin
      check("t5a_so", bus.sound_out, ((t / 2) % 2) == 0);
      bus.req[1] = (t % 2 == 1);
      @(negedge clk);
    end
    bus.req[1] = 1'b0;
    check_tone("t5a", 2, 6, 4);
    wait_grant("t5b", 4'b0010, 1, 1);
    check_tone("t5b", 2, 6, 0);
    expect_quiet("t5_absorb", 12);

    // Reset mid-tone with a queued request and req[2] held through release
    set_fields(1, 4, 100);
    set_fields(2, 3, 6);
    bus.req[1] = 1'b1;
    wait_grant("t6a", 4'b0010, 1, 2);
    bus.req[1] = 1'b0;
    bus.req[3] = 1'b1;
    @(negedge clk);
    bus.req[3] = 1'b0;
    bus.req[2] = 1'b1;
    @(negedge clk);
    check("t6_pre_so", bus.sound_out, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_rst_so", bus.sound_out, 1'b0);
    check("t6_rst_busy", bus.busy, 1'b0);
    check("t6_rst_grant", bus.grant, 4'b0000);
    check("t6_rst_id", bus.active_id, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_grant("t6b", 4'b0100, 2, 2);
    check_tone("t6b", 3, 6, 0);
    expect_quiet("t6_no_resume", 20);
    bus.req[2] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
